// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
package loader_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned INSTR_W   = 15;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned LITERAL_W = 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StChk,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit XOR accumulator; clear has priority over enable.
module loader_checksum (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (en_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Parses a framed byte stream (sync, length, hi/lo pairs, checksum) into
// instruction-memory writes while holding the CPU stalled.
module program_loader
  import loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  input  logic [7:0]         in_data_i,
  output logic               in_ready_o,
  output logic               im_we_o,
  output logic [ADDR_W-1:0]  im_addr_o,
  output logic [INSTR_W-1:0] im_wdata_o,
  output logic               cpu_hold_o,
  output logic               load_done_o,
  output logic               load_error_o,
  output logic [8:0]         words_loaded_o
);

  state_e                state_q, state_d;
  logic [8:0]            count_q, count_d;
  logic [8:0]            words_q, words_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [INSTR_W-1:0]    wdata_q, wdata_d;

  logic       accept;
  logic       ck_clr, ck_en;
  logic [7:0] ck_sum;
  logic [8:0] words_inc;

  // Never back-pressures; ready only drops while reset is asserted.
  assign in_ready_o = ~reset_i;
  assign accept     = in_valid_i & in_ready_o;
  assign words_inc  = words_q + 9'd1;

  loader_checksum u_checksum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (ck_clr),
    .en_i    (ck_en),
    .data_i  (in_data_i),
    .sum_o   (ck_sum)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    words_d  = words_q;
    opcode_d = opcode_q;
    done_d   = done_q;
    error_d  = error_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ck_clr   = 1'b0;
    ck_en    = 1'b0;

    if (accept) begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (in_data_i == SYNC_BYTE) begin
            state_d = StLen;
            done_d  = 1'b0;
            error_d = 1'b0;
            words_d = 9'd0;
            ck_clr  = 1'b1;
          end
        end
        StLen: begin
          // A zero length byte encodes a full 256-word image.
          count_d = (in_data_i == 8'h00) ? 9'd256 : {1'b0, in_data_i};
          ck_en   = 1'b1;
          state_d = StHi;
        end
        StHi: begin
          if (in_data_i[7]) begin
            error_d = 1'b1;
            state_d = StError;
          end else begin
            opcode_d = in_data_i[OPCODE_W-1:0];
            ck_en    = 1'b1;
            state_d  = StLo;
          end
        end
        StLo: begin
          ck_en   = 1'b1;
          we_d    = 1'b1;
          addr_d  = words_q[ADDR_W-1:0];
          wdata_d = {opcode_q, in_data_i};
          words_d = words_inc;
          state_d = (words_inc < count_q) ? StHi : StChk;
        end
        StChk: begin
          if (in_data_i == ck_sum) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            error_d = 1'b1;
            state_d = StError;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      count_q  <= 9'd0;
      words_q  <= 9'd0;
      opcode_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      words_q  <= words_d;
      opcode_q <= opcode_d;
      done_q   <= done_d;
      error_q  <= error_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign im_we_o        = we_q;
  assign im_addr_o      = addr_q;
  assign im_wdata_o     = wdata_q;
  assign cpu_hold_o     = (state_q != StIdle) && (state_q != StDone);
  assign load_done_o    = done_q;
  assign load_error_o   = error_q;
  assign words_loaded_o = words_q;

endmodule
